// File: rtl/qracc_pkg.sv
// Shared types and defaults for the qracc requantize/drain stage.
package qracc_pkg;
    localparam int QRACC_REQUANT_LANES      = 4;
    localparam int QRACC_REQUANT_FIFO_DEPTH = 4;
    localparam int QRACC_MULT_BITS          = 16;
    localparam int QRACC_SHIFT_BITS         = 5;
    localparam int QRACC_OUT_BITS           = 8;

    typedef struct packed {
        logic [QRACC_MULT_BITS-1:0]        mult;
        logic [QRACC_SHIFT_BITS-1:0]       shift;
        logic signed [QRACC_OUT_BITS-1:0]  zp;
        logic                              relu_en;
    } qracc_requant_cfg_t;

    typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} qracc_drain_state_t;
endpackage

// File: rtl/qracc_vec_fifo.sv
// Synchronous vector FIFO; a push while full is accepted only alongside a pop.
module qracc_vec_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [width-1:0]        din,
    output logic [width-1:0]        head,
    output logic [$clog2(depth):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    assign full  = (count == (AW+1)'(depth));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr];

    // When full with a pop, the write lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
endmodule

// File: rtl/qracc_requant_drain.sv
// Buffers seq_acc vectors, requantizes them and drains them as lane-wide beats.
// Define QRACC_REQUANT_ROUND_EN for round-half-up before the shift (default truncates).
module qracc_requant_drain
    import qracc_pkg::*;
#(
    parameter int outputElements = 32,
    parameter int accBits        = 16,
    parameter int outBits        = 8,
    parameter int lanes          = QRACC_REQUANT_LANES,
    parameter int fifoDepth      = QRACC_REQUANT_FIFO_DEPTH,
    parameter int multBits       = 16,
    parameter int shiftBits      = 5
) (
    input  logic                                       clk,
    input  logic                                       nrst,
    input  qracc_requant_cfg_t                         cfg_i,
    input  logic                                       acc_valid_i,
    input  logic [outputElements-1:0][accBits-1:0]     acc_data_i,
    output logic                                       out_valid_o,
    input  logic                                       out_ready_i,
    output logic [lanes-1:0][outBits-1:0]              out_data_o,
    output logic [$clog2(outputElements/lanes)-1:0]    out_beat_o,
    output logic                                       out_last_o,
    output logic                                       drop_o,
    output logic [$clog2(fifoDepth):0]                 fifo_count_o,
    output logic                                       busy_o
);
    localparam int N   = outputElements / lanes;
    localparam int BW  = $clog2(N);
    localparam int CW  = $clog2(outputElements);
    localparam int NW  = $clog2(fifoDepth) + 1;
    localparam int PW  = accBits + multBits + 1;
    localparam logic [BW-1:0]           LAST_BEAT = BW'(N - 1);
    localparam logic signed [PW:0]      SAT_HI    = (PW+1)'((2 ** (outBits - 1)) - 1);
    localparam logic signed [PW:0]      SAT_LO    = -SAT_HI - 1;
    localparam logic signed [outBits-1:0] Y_MAX   = {1'b0, {(outBits-1){1'b1}}};
    localparam logic signed [outBits-1:0] Y_MIN   = {1'b1, {(outBits-1){1'b0}}};

    qracc_drain_state_t                       state_q, state_d;
    logic [BW-1:0]                            bc_q, bc_d;
    qracc_requant_cfg_t                       cfg_q, cfg_eff;
    logic                                     load, pop, cap_cfg;
    logic                                     fifo_full, fifo_empty;
    logic [outputElements-1:0][accBits-1:0]   head_vec;
    logic [lanes-1:0][outBits-1:0]            lane_y;
    logic [CW-1:0]                            beat_base;
    logic [shiftBits-1:0]                     sh;
    logic signed [PW-1:0]                     bias;

    qracc_vec_fifo #(.width(outputElements * accBits), .depth(fifoDepth)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (acc_valid_i),
        .pop   (pop),
        .din   (acc_data_i),
        .head  (head_vec),
        .count (fifo_count_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            bc_q    <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            if (cap_cfg) cfg_q <= cfg_i;
        end
    end

    // Beat 0 of a vector leaving IDLE loads on the same edge that captures cfg.
    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        cap_cfg = 1'b0;
        pop     = 1'b0;
        load    = !fifo_empty && (!out_valid_o || out_ready_i);
        case (state_q)
            S_IDLE: if (!fifo_empty) begin
                state_d = S_DRAIN;
                cap_cfg = 1'b1;
            end
            default: ;
        endcase
        if (load) begin
            if (bc_q == LAST_BEAT) begin
                pop  = 1'b1;
                bc_d = '0;
                if (fifo_count_o > NW'(1) || acc_valid_i) begin
                    state_d = S_DRAIN;
                    cap_cfg = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                bc_d = bc_q + 1'b1;
            end
        end
    end

    assign cfg_eff   = (state_q == S_IDLE) ? cfg_i : cfg_q;
    assign sh        = cfg_eff.shift;
    assign beat_base = CW'(int'(bc_q) * lanes);

    always_comb begin
        bias = '0;
`ifdef QRACC_REQUANT_ROUND_EN
        if (sh != '0) bias = PW'(1) << (sh - 1'b1);
`endif
    end

    for (genvar j = 0; j < lanes; j++) begin : g_lane
        logic [CW-1:0]          col;
        logic signed [PW-1:0]   prod, biased, shifted;
        logic signed [PW:0]     sum;
        logic signed [outBits-1:0] y;

        assign col = beat_base + CW'(j);

        always_comb begin
            prod    = PW'($signed(head_vec[col])) * PW'($signed({1'b0, cfg_eff.mult}));
            biased  = prod + bias;
            shifted = biased >>> sh;
            sum     = (PW+1)'(shifted) + (PW+1)'(cfg_eff.zp);
            if (sum > SAT_HI)      y = Y_MAX;
            else if (sum < SAT_LO) y = Y_MIN;
            else                   y = sum[outBits-1:0];
            if (cfg_eff.relu_en && y < cfg_eff.zp) y = cfg_eff.zp;
        end

        assign lane_y[j] = y;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_beat_o  <= '0;
            out_last_o  <= 1'b0;
            drop_o      <= 1'b0;
        end else begin
            drop_o <= acc_valid_i && fifo_full && !pop;
            if (load) begin
                out_valid_o <= 1'b1;
                out_data_o  <= lane_y;
                out_beat_o  <= bc_q;
                out_last_o  <= (bc_q == LAST_BEAT);
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

    assign busy_o = !fifo_empty || out_valid_o;
endmodule

// File: tb/tb_qracc_requant_drain.sv
// Randomized + directed bench for qracc_requant_drain with a vector-level reference model.
module tb_qracc_requant_drain;
    import qracc_pkg::*;

    localparam int OE = 32, AB = 16, OB = 8, L = 4, FD = 4, N = OE / L;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    qracc_requant_cfg_t cfg;
    logic acc_valid, out_ready, out_valid, out_last, drop, busy;
    logic [OE-1:0][AB-1:0] acc_data;
    logic [L-1:0][OB-1:0] out_data;
    logic [$clog2(N)-1:0] out_beat;
    logic [$clog2(FD):0] fcount;

    int checks = 0, failures = 0;

    typedef struct {
        logic [L-1:0][OB-1:0] d;
        int beat;
    } beat_t;
    beat_t exp_q[$];

    qracc_requant_drain #(
        .outputElements(OE), .accBits(AB), .outBits(OB), .lanes(L),
        .fifoDepth(FD), .multBits(16), .shiftBits(5)
    ) dut (
        .clk(clk), .nrst(nrst), .cfg_i(cfg), .acc_valid_i(acc_valid), .acc_data_i(acc_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_beat_o(out_beat), .out_last_o(out_last), .drop_o(drop),
        .fifo_count_o(fcount), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Requantize one accumulator straight from the arithmetic rules.
    function automatic logic [OB-1:0] rq(input logic signed [AB-1:0] a, input qracc_requant_cfg_t c);
        longint v;
        v = longint'(a) * longint'(c.mult);
`ifdef QRACC_REQUANT_ROUND_EN
        if (c.shift != 0) v = v + (longint'(1) << (c.shift - 1));
`endif
        v = v >>> c.shift;
        v = v + longint'(c.zp);
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        if (c.relu_en && v < longint'(c.zp)) v = longint'(c.zp);
        return OB'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int m, input int s, input int z, input bit r);
        cfg.mult = 16'(m);
        cfg.shift = 5'(s);
        cfg.zp = 8'(z);
        cfg.relu_en = r;
    endtask

    task automatic rand_vec();
        for (int k = 0; k < OE; k++) acc_data[k] = AB'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
        tick();
    endtask

    // Push one vector into an idle DUT with ready high and return beat 0.
    task automatic one_vec(input logic [OE-1:0][AB-1:0] v, output logic [L-1:0][OB-1:0] b0);
        acc_valid = 1'b1;
        acc_data = v;
        tick();
        acc_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("lat_beat", out_beat, 0);
        b0 = out_data;
        wait_idle();
    endtask

    // Scoreboard: every accepted beat must match the model, in push order.
    initial begin : monitor
        logic pend;
        logic [OE-1:0][AB-1:0] pend_v;
        qracc_requant_cfg_t pend_c;
        int pend_cnt;
        logic held;
        beat_t held_b;
        beat_t e;
        pend = 1'b0;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                exp_q.delete();
                pend = 1'b0;
                held = 1'b0;
            end else begin
                if (drop) begin
                    chk("drop_cause", longint'(pend && pend_cnt == FD), 1);
                end else if (pend) begin
                    for (int b = 0; b < N; b++) begin
                        e.beat = b;
                        for (int j = 0; j < L; j++) e.d[j] = rq(pend_v[b*L+j], pend_c);
                        exp_q.push_back(e);
                    end
                end
                pend = acc_valid;
                pend_v = acc_data;
                pend_c = cfg;
                pend_cnt = int'(fcount);
                if (held) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, held_b.d);
                    chk("hold_beat", out_beat, held_b.beat);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("beat_expected", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", out_data, e.d);
                        chk("beat_idx", out_beat, e.beat);
                        chk("beat_last", out_last, longint'(e.beat == N - 1));
                    end
                end
                held = out_valid && !out_ready;
                held_b.d = out_data;
                held_b.beat = int'(out_beat);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [OE-1:0][AB-1:0] v;
        logic [L-1:0][OB-1:0] b0, hold;
        int nacc;
        logic seen;
        acc_valid = 1'b0;
        out_ready = 1'b0;
        acc_data = '0;
        cfg = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_beat", out_beat, 0);
        chk("rst_last", out_last, 0);
        chk("rst_drop", drop, 0);
        chk("rst_count", fcount, 0);
        chk("rst_busy", busy, 0);
        tick();
        nrst = 1'b1;
        tick();

        // Single vector: acc[k]=4k, shift 2 -> beat b lanes = 4b..4b+3.
        set_cfg(1, 2, 0, 0);
        out_ready = 1'b1;
        for (int k = 0; k < OE; k++) v[k] = AB'(4 * k);
        acc_valid = 1'b1;
        acc_data = v;
        tick();
        acc_valid = 1'b0;
        @(negedge clk);
        chk("sv_c1_valid", out_valid, 0);
        for (int c = 2; c <= 9; c++) begin
            tick();
            @(negedge clk);
            chk("sv_valid", out_valid, 1);
            chk("sv_beat", out_beat, c - 2);
            chk("sv_last", out_last, longint'(c == 9));
            chk("sv_lane0", out_data[0], 4 * (c - 2));
            chk("sv_lane3", out_data[3], 4 * (c - 2) + 3);
        end
        chk("sv_busy9", busy, 1);
        tick();
        @(negedge clk);
        chk("sv_busy10", busy, 0);
        chk("sv_valid10", out_valid, 0);
        tick();

        // Rounding and saturation.
        v = '0;
        v[0] = AB'(-3);
        v[1] = AB'(5);
        v[2] = AB'(1000);
        v[3] = AB'(-1000);
        set_cfg(1, 1, 0, 0);
        one_vec(v, b0);
`ifdef QRACC_REQUANT_ROUND_EN
        chk("rnd_neg", longint'($signed(b0[0])), -1);
        chk("rnd_pos", longint'($signed(b0[1])), 3);
`else
        chk("rnd_neg", longint'($signed(b0[0])), -2);
        chk("rnd_pos", longint'($signed(b0[1])), 2);
`endif
        set_cfg(1, 0, 0, 0);
        one_vec(v, b0);
        chk("sat_hi", longint'($signed(b0[2])), 127);
        chk("sat_lo", longint'($signed(b0[3])), -128);

        // ReLU with zero point 10.
        v[0] = AB'(-50);
        v[1] = AB'(50);
        v[2] = AB'(200);
        v[3] = '0;
        set_cfg(1, 0, 10, 1);
        one_vec(v, b0);
        chk("relu_neg", longint'($signed(b0[0])), 10);
        chk("relu_pos", longint'($signed(b0[1])), 60);
        chk("relu_sat", longint'($signed(b0[2])), 127);
        chk("relu_zero", longint'($signed(b0[3])), 10);

        // Backpressure: five pushes into a stalled stream, the fifth drops.
        set_cfg(3, 1, -5, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            acc_valid = 1'b1;
            rand_vec();
            tick();
        end
        acc_valid = 1'b0;
        @(negedge clk);
        chk("bp_count", fcount, 4);
        chk("bp_drop", drop, 1);
        chk("bp_valid", out_valid, 1);
        chk("bp_beat", out_beat, 0);
        hold = out_data;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk("bp_drop_once", drop, 0);
            chk("bp_hold", out_data, hold);
        end
        tick();
        out_ready = 1'b1;
        nacc = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid && out_ready) nacc++;
            tick();
        end
        chk("bp_beats", nacc, 32);
        chk("bp_idle", busy, 0);

        // Full FIFO: push lands on the edge that pops the head.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc_valid = 1'b1;
            rand_vec();
            tick();
        end
        acc_valid = 1'b0;
        @(negedge clk);
        chk("fp_count_full", fcount, 4);
        tick();
        out_ready = 1'b1;
        repeat (6) tick();
        acc_valid = 1'b1;
        rand_vec();
        @(negedge clk);
        chk("fp_count_pre", fcount, 4);
        chk("fp_beat6", out_beat, 6);
        tick();
        acc_valid = 1'b0;
        @(negedge clk);
        chk("fp_no_drop", drop, 0);
        chk("fp_count_post", fcount, 4);
        chk("fp_beat7", out_beat, 7);
        wait_idle();

        // Reset in the middle of a drain.
        set_cfg(2, 3, 1, 0);
        acc_valid = 1'b1;
        rand_vec();
        tick();
        acc_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("mr_beat3", out_beat, 3);
        #2;
        nrst = 1'b0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_beat", out_beat, 0);
        chk("mr_count", fcount, 0);
        chk("mr_busy", busy, 0);
        tick();
        tick();
        nrst = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
            tick();
        end
        chk("mr_quiet", seen, 0);
        acc_valid = 1'b1;
        rand_vec();
        tick();
        acc_valid = 1'b0;
        wait_idle();

        // Randomized traffic, cfg fixed per batch.
        for (int bt = 0; bt < 4; bt++) begin
            set_cfg((bt % 2 == 0) ? int'($urandom_range(1, 255)) : int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 255)),
                    bit'($urandom_range(0, 1)));
            for (int c = 0; c < 250; c++) begin
                acc_valid = ($urandom_range(0, 3) == 0);
                rand_vec();
                out_ready = ($urandom_range(0, 9) < 7);
                tick();
            end
            acc_valid = 1'b0;
            out_ready = 1'b1;
            wait_idle();
        end

        @(negedge clk);
        chk("exp_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/qracc_requant_drain.md
# qracc_requant_drain

Downstream stage of `seq_acc`. Captures each full-width accumulator vector on `valid_o`/`mac_data_o`, buffers it in a small vector FIFO, and requantizes it to `outBits` using a per-run multiplier, shift, zero point and optional ReLU. It then drains the vector as a narrow valid/ready stream of `lanes` outputs per beat toward the output SRAM/DMA writeback. `seq_acc` has no backpressure input, so this block absorbs bursts and flags any vector it must drop.

## Interface
Parameters:
- `outputElements`, 32: columns per accumulator vector; must be divisible by `lanes`.
- `accBits`, 16: signed accumulator width; matches `seq_acc` output.
- `outBits`, 8: signed requantized output width.
- `lanes`, 4: outputs per output beat.
- `fifoDepth`, 4: vector FIFO depth; power of two, ≥2.
- `multBits`, 16: unsigned multiplier width.
- `shiftBits`, 5: right-shift amount width.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `cfg_i`  in  `qracc_requant_cfg_t`  fields: `mult` [multBits], `shift` [shiftBits], `zp` signed [outBits], `relu_en` 1.
- `acc_valid_i`  in  1  vector present; single-cycle qualifier, no ready.
- `acc_data_i`  in  [outputElements][accBits]  signed accumulators.
- `out_valid_o`  out  1  beat valid.
- `out_ready_i`  in  1  beat accepted when high with `out_valid_o`.
- `out_data_o`  out  [lanes][outBits]  signed requantized outputs; lane j of beat b = column b*lanes+j.
- `out_beat_o`  out  clog2(outputElements/lanes)  beat index within vector.
- `out_last_o`  out  1  final beat of vector.
- `drop_o`  out  1  one-cycle pulse: incoming vector discarded (FIFO full).
- `fifo_count_o`  out  clog2(fifoDepth)+1  vectors held.
- `busy_o`  out  1  FIFO non-empty or `out_valid_o` high.

## Operation
- **Push.** `acc_valid_i` high at an edge writes `acc_data_i` to the FIFO. The write is accepted if count < fifoDepth, or if a pop occurs in the same cycle.
  - Otherwise the vector is discarded and `drop_o` is high the next cycle.
  - Push and pop in the same cycle leave the count unchanged.
- **Drain FSM** (S_IDLE, S_DRAIN), with beat counter `bc`.
  - S_IDLE → S_DRAIN when the FIFO is non-empty. `cfg_i` is captured into a shadow register at that edge, so cfg changes take effect only at vector boundaries.
  - In S_DRAIN the output register loads the beat selected by `bc` from the FIFO head whenever `!out_valid_o || out_ready_i`.
  - `bc` increments per load. Loading beat N-1 (N = outputElements/lanes) pops the head and resets `bc` to 0.
  - If the FIFO still holds a vector after the pop, the FSM stays in S_DRAIN, re-captures cfg and continues with no bubble. Otherwise it returns to S_IDLE.
- **Output register.** Holds data, beat and last stable while `out_valid_o && !out_ready_i`. `out_valid_o` clears when a beat is accepted and no new beat loads.
- **Arithmetic, per lane:**
  - p = acc × mult, signed, accBits+multBits+1 bits.
  - Rounding per Configuration, then arithmetic right shift by `shift` (0 = none).
  - Add zp sign-extended.
  - Saturate to [−2^(outBits−1), 2^(outBits−1)−1].
  - If `relu_en`, lower bound becomes zp, i.e. y = max(y, zp).
- **Reset** (async, any time): FIFO emptied, FSM → S_IDLE, `bc` = 0. In-flight vectors are lost and no beats are emitted after release until a new push.

## Timing
- Reset values: `out_valid_o` 0, `out_data_o` 0, `out_beat_o` 0, `out_last_o` 0, `drop_o` 0, `fifo_count_o` 0, `busy_o` 0.
- Latency: `acc_valid_i` in cycle 0 with the FIFO empty → beat 0 has `out_valid_o` high in cycle 2.
- Throughput: one beat/cycle with `out_ready_i` held high. A vector drains in N cycles; back-to-back vectors have no gap.
- `fifo_count_o` updates the cycle after the push/pop edge.
- `drop_o` is high for exactly one cycle per dropped vector.

## Configuration
- `QRACC_REQUANT_ROUND_EN` defined: before the shift, add 2^(shift−1) when shift > 0 (round half toward +inf).
- `QRACC_REQUANT_ROUND_EN` undefined: no bias is added; the shift truncates toward −inf.
- The shift and saturation logic is identical in both builds.

## Structure
- `qracc_pkg` holds:
  - `qracc_requant_cfg_t`;
  - the drain FSM state enum `qracc_drain_state_t`;
  - default constants `QRACC_REQUANT_LANES`, `QRACC_REQUANT_FIFO_DEPTH`.
- One sub-module, `qracc_vec_fifo`: a parameterized (width, depth) synchronous FIFO with async active-low reset. It exposes push, pop, head, count, full and empty.
- Arithmetic stays inline in a generate loop over lanes.

## Test plan
- **Single vector.** acc[k]=4k; mult=1, shift=2, zp=0, relu off; ready=1 → 8 beats from cycle 2. Beat b = {4b..4b+3}. `out_last_o` only on beat 7; `busy_o` low from cycle 10.
- **Rounding and saturation** (mult=1).
  - acc=−3, shift=1 → −1 with ROUND_EN, −2 without.
  - acc=5, shift=1 → 3 with ROUND_EN, 2 without.
  - acc=1000, shift=0 → 127; acc=−1000, shift=0 → −128.
- **ReLU.** zp=10, relu_en=1, mult=1, shift=0 → acc −50 → 10; acc 50 → 60; acc 200 → 127.
- **Backpressure and drop.** ready=0; 5 vectors on consecutive cycles → `fifo_count_o`=4, `drop_o` pulses once, beat 0 of vector 0 held stable. Then ready=1 → 32 beats in push order.
- **Full with simultaneous pop.** FIFO at 4; push on the same cycle the head's beat 7 loads → accepted, `drop_o` stays 0, count stays 4.
- **Reset mid-drain.** nrst=0 during beat 3 → all outputs 0 asynchronously. After release, no beats until a new `acc_valid_i`.
